// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with valid/ready input handshake and a bit-enable strobe.
// Words may be chained back-to-back: the next word loads while the last bit of the current one is consumed.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             bit_en,
    output logic             o,
    output logic             o_valid,
    output logic             busy
);

    localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shreg;
    logic             r_o;
    logic             r_o_valid;
    logic             w_load;
    logic             w_advance;
    logic             w_drain;

    // Bit that leaves the word first, given the configured order.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Remaining bits after the first one has been taken.
    function automatic logic [WIDTH-1:0] drop_first(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        data_ready  = 1'b0;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        w_drain     = 1'b0;
        case (r_state)
            S_IDLE: begin
                data_ready = 1'b1;
                if (data_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bit_en) begin
                    if (r_cnt == LAST) begin
                        // Last bit is leaving: a waiting word is chained in with no gap.
                        data_ready = 1'b1;
                        if (data_valid) begin
                            w_load = 1'b1;
                        end else begin
                            w_drain     = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_shreg   <= '0;
            r_o       <= IDLE_BIT;
            r_o_valid <= 1'b0;
        end else if (w_load) begin
            r_cnt     <= '0;
            r_shreg   <= drop_first(data_in);
            r_o       <= first_bit(data_in);
            r_o_valid <= 1'b1;
        end else if (w_advance) begin
            r_cnt     <= r_cnt + CNT_W'(1);
            r_shreg   <= drop_first(r_shreg);
            r_o       <= first_bit(r_shreg);
        end else if (w_drain) begin
            r_cnt     <= '0;
            r_shreg   <= '0;
            r_o       <= IDLE_BIT;
            r_o_valid <= 1'b0;
        end
    end

    assign o       = r_o;
    assign o_valid = r_o_valid;
    assign busy    = (r_state == S_SHIFT);

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: two instances (MSB-first/idle 0 and LSB-first/idle 1) against a bit-queue model.
module tb_bit_serializer;

    localparam int W = 8;

    logic         clk        = 1'b0;
    logic         reset      = 1'b1;
    logic [W-1:0] data_in    = '0;
    logic         data_valid = 1'b0;
    logic         bit_en     = 1'b1;

    logic rdy_m, o_m, ov_m, bz_m;
    logic rdy_l, o_l, ov_l, bz_l;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model: the bits still to be shown, in transmit order, per instance.
    bit q_m[$];
    bit q_l[$];

    logic [31:0] s_m, s_l, s_r, s_v;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(rdy_m), .bit_en(bit_en), .o(o_m), .o_valid(ov_m), .busy(bz_m)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(rdy_l), .bit_en(bit_en), .o(o_l), .o_valid(ov_l), .busy(bz_l)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // A word accepted at an edge is queued whole; the head bit leaves on each edge with bit_en high.
    always @(posedge clk) begin
        bit rdy;
        rdy = (q_m.size() == 0) || (q_m.size() == 1 && bit_en);
        if (reset) begin
            q_m.delete();
            q_l.delete();
        end else begin
            if (q_m.size() != 0 && bit_en) begin
                void'(q_m.pop_front());
                void'(q_l.pop_front());
            end
            if (data_valid && rdy) begin
                for (int i = 0; i < W; i++) begin
                    q_m.push_back(data_in[W-1-i]);
                    q_l.push_back(data_in[i]);
                end
            end
        end
    end

    always @(negedge clk) begin
        bit e_v;
        bit e_r;
        if (chk_en) begin
            e_v = (q_m.size() != 0);
            e_r = (q_m.size() == 0) || (q_m.size() == 1 && bit_en);
            chk("m_o",     o_m,   e_v ? q_m[0] : 1'b0);
            chk("l_o",     o_l,   e_v ? q_l[0] : 1'b1);
            chk("m_oval",  ov_m,  e_v);
            chk("l_oval",  ov_l,  e_v);
            chk("m_busy",  bz_m,  e_v);
            chk("l_busy",  bz_l,  e_v);
            chk("m_ready", rdy_m, e_r);
            chk("l_ready", rdy_l, e_r);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        @(negedge clk);
        chk({tag, "_o_m"},   o_m,   1'b0);
        chk({tag, "_o_l"},   o_l,   1'b1);
        chk({tag, "_oval"},  ov_m,  1'b0);
        chk({tag, "_busy"},  bz_m,  1'b0);
        chk({tag, "_ready"}, rdy_m, 1'b1);
    endtask

    task automatic sample();
        s_m = {s_m[30:0], o_m};
        s_l = {s_l[30:0], o_l};
        s_r = {s_r[30:0], rdy_m};
        s_v = {s_v[30:0], ov_m};
    endtask

    // Offer one word for one cycle from IDLE, then record ncyc output cycles.
    task automatic send_collect(input logic [W-1:0] w, input int ncyc, input bit toggle);
        s_m = '0; s_l = '0; s_r = '0; s_v = '0;
        data_in    = w;
        data_valid = 1'b1;
        bit_en     = 1'b1;
        step();
        data_valid = 1'b0;
        data_in    = W'($urandom);
        for (int i = 1; i <= ncyc; i++) begin
            bit_en = toggle ? (i % 2 == 0) : 1'b1;
            @(negedge clk);
            sample();
            step();
        end
        bit_en = 1'b1;
    endtask

    initial begin
        int  rises;
        bit  last_acc;

        reset = 1'b1;
        step();
        chk_en = 1'b1;
        chk_idle("rst");
        step();
        reset = 1'b0;

        // Single word, MSB first and LSB first in parallel
        send_collect(8'hB3, 8, 1'b0);
        chk("t1_seq_m", s_m, 32'hB3);
        chk("t1_seq_l", s_l, 32'hCD);
        chk("t1_ready", s_r, 32'h01);
        chk("t1_oval",  s_v, 32'hFF);
        chk_idle("t1_end");
        step();

        // Back-to-back words with data_valid held
        s_m = '0; s_l = '0; s_r = '0; s_v = '0;
        data_in    = 8'hFF;
        data_valid = 1'b1;
        step();
        data_in = 8'h01;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            sample();
            step();
            if (i == 8) data_valid = 1'b0;
        end
        chk("t2_seq_m", s_m, 32'hFF01);
        chk("t2_seq_l", s_l, 32'hFF80);
        chk("t2_ready", s_r, 32'h0101);
        chk("t2_oval",  s_v, 32'hFFFF);
        chk_idle("t2_end");
        step();

        // bit_en toggling: each bit held two cycles
        send_collect(8'hA5, 16, 1'b1);
        chk("t3_seq_m", s_m, 32'hCC33);
        chk("t3_seq_l", s_l, 32'hCC33);
        chk("t3_ready", s_r, 32'h0001);
        chk("t3_oval",  s_v, 32'hFFFF);
        chk_idle("t3_end");
        step();

        // LSB-first ordering
        send_collect(8'h06, 8, 1'b0);
        chk("t4_seq_l", s_l, 32'h60);
        chk("t4_seq_m", s_m, 32'h06);
        chk_idle("t4_end");
        step();

        // Reset on the 4th bit discards the word
        data_in    = 8'hF0;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        @(negedge clk);
        chk("t5_bit4_m", o_m, 1'b1);
        chk("t5_bit4_l", o_l, 1'b0);
        step();
        reset = 1'b0;
        chk_idle("t5_rst");
        step();
        send_collect(8'h0F, 8, 1'b0);
        chk("t5_seq_m", s_m, 32'h0F);
        chk("t5_seq_l", s_l, 32'hF0);
        chk_idle("t5_end");
        step();

        // Stream feeding the pattern detector: two 0->1 transitions
        send_collect(8'h6E, 8, 1'b0);
        chk("t6_seq_m", s_m, 32'h6E);
        rises = 0;
        for (int j = 7; j >= 1; j--) begin
            if (!s_m[j] && s_m[j-1]) rises++;
        end
        chk("t6_rises", rises, 2);
        chk_idle("t6_end");
        step();

        // Randomized traffic; source holds a word until it is taken
        last_acc = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (!data_valid || last_acc) begin
                data_valid = ($urandom_range(0, 3) != 0);
                data_in    = W'($urandom);
            end
            bit_en = ($urandom_range(0, 9) < 7);
            reset  = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            last_acc = (data_valid && rdy_m) || reset;
            step();
        end
        reset      = 1'b0;
        data_valid = 1'b0;
        bit_en     = 1'b1;
        repeat (20) step();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
